fir_pulse_detector: RTL and testbench

Consumes the 20-bit filtered photoplethysmogram stream produced by the FIR low-pass stage and extracts pulse events. It tracks alternating peaks and troughs with hysteresis, measures the peak-to-peak period in samples, and reports peak, trough and amplitude per beat. Downstream heart-rate and SpO2 ratio logic reads its outputs.

---
 rtl/fir_pulse_pkg.sv | 17 +
 rtl/fir_extremum_tracker.sv | 60 ++++++
 rtl/fir_pulse_detector.sv | 143 ++++++++++++++
 tb/tb_fir_pulse_detector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pulse_pkg.sv
// Shared types and default constants for the PPG pulse detector.
package fir_pulse_pkg;

  localparam int DATA_W           = 20;
  localparam int PERIOD_W         = 16;
  localparam int DEF_HYST         = 64;
  localparam int DEF_WARMUP       = 24;
  localparam int DEF_MIN_PERIOD   = 20;
  localparam int DEF_MAX_PERIOD   = 400;

  typedef enum logic [1:0] {
    WARM     = 2'd0,
    SEEK_MAX = 2'd1,
    SEEK_MIN = 2'd2
  } state_t;

endpackage

// File: rtl/fir_extremum_tracker.sv
// Running max/min tracker with hysteresis-qualified peak and trough detection.
// Equal samples never replace the running extremum, so the earliest one is kept.
module fir_extremum_tracker #(
  parameter int DATA_W = fir_pulse_pkg::DATA_W,
  parameter int HYST   = fir_pulse_pkg::DEF_HYST
) (
  input  logic              CLK_Filter,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              load,
  input  logic              track,
  input  logic              seek_max,
  input  logic [DATA_W-1:0] sample,
  output logic              peak_confirm,
  output logic              trough_confirm,
  output logic [DATA_W-1:0] extremum
);
  import fir_pulse_pkg::*;

  localparam int EW = DATA_W + 1;
  localparam logic [EW-1:0] HYST_EXT = EW'(HYST);

  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] run_min;
  logic [EW-1:0]     sample_ext;

  // Compares are done one bit wider so sample+HYST cannot wrap.
  assign sample_ext     = {1'b0, sample};
  assign peak_confirm   = sample_en && track && seek_max &&
                          ((sample_ext + HYST_EXT) < {1'b0, run_max});
  assign trough_confirm = sample_en && track && !seek_max &&
                          (sample_ext > ({1'b0, run_min} + HYST_EXT));
  assign extremum       = seek_max ? run_max : run_min;

  // Follow the current extremum; on confirmation seed the opposite one from the sample.
  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      run_max <= '0;
      run_min <= '0;
    end else if (sample_en) begin
      if (load) begin
        run_max <= sample;
        run_min <= sample;
      end else if (track) begin
        if (seek_max) begin
          if (peak_confirm)
            run_min <= sample;
          else if (sample > run_max)
            run_max <= sample;
        end else begin
          if (trough_confirm)
            run_max <= sample;
          else if (sample < run_min)
            run_min <= sample;
        end
      end
    end
  end

endmodule

// File: rtl/fir_pulse_detector.sv
// Beat extraction from the filtered PPG stream: alternating peak/trough search,
// peak-to-peak period measurement, amplitude and lock/timeout reporting.
module fir_pulse_detector #(
  parameter int DATA_W     = fir_pulse_pkg::DATA_W,
  parameter int HYST       = fir_pulse_pkg::DEF_HYST,
  parameter int WARMUP     = fir_pulse_pkg::DEF_WARMUP,
  parameter int MIN_PERIOD = fir_pulse_pkg::DEF_MIN_PERIOD,
  parameter int MAX_PERIOD = fir_pulse_pkg::DEF_MAX_PERIOD,
  parameter int PERIOD_W   = fir_pulse_pkg::PERIOD_W
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [DATA_W-1:0]   Filtered_In,
  output logic                pulse_valid,
  output logic [PERIOD_W-1:0] pulse_period,
  output logic [DATA_W-1:0]   peak_value,
  output logic [DATA_W-1:0]   trough_value,
  output logic [DATA_W-1:0]   amplitude,
  output logic                locked,
  output logic                timeout
);
  import fir_pulse_pkg::*;

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam logic [WARM_W-1:0]   WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P     = PERIOD_W'(MAX_PERIOD);

  state_t              state;
  state_t              state_next;
  logic [WARM_W-1:0]   warm_cnt;
  logic                load;
  logic                peak_confirm;
  logic                trough_confirm;
  logic [DATA_W-1:0]   extremum;
  logic [PERIOD_W-1:0] since_peak;
  logic [PERIOD_W-1:0] since_inc;
  logic [PERIOD_W-1:0] period_cand;
  logic                has_ref;
  logic                accept;
  logic                timeout_hit;
  logic [DATA_W-1:0]   amp_next;

  fir_extremum_tracker #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_tracker (
    .CLK_Filter     (CLK_Filter),
    .rst_n          (rst_n),
    .sample_en      (sample_en),
    .load           (load),
    .track          (state != WARM),
    .seek_max       (state == SEEK_MAX),
    .sample         (Filtered_In),
    .peak_confirm   (peak_confirm),
    .trough_confirm (trough_confirm),
    .extremum       (extremum)
  );

  // Next-state: leave WARM on the last warm-up sample, then alternate on confirmations.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      WARM: begin
        if (sample_en && (warm_cnt == WARM_LAST)) begin
          load       = 1'b1;
          state_next = SEEK_MAX;
        end
      end
      SEEK_MAX: if (peak_confirm)   state_next = SEEK_MIN;
      SEEK_MIN: if (trough_confirm) state_next = SEEK_MAX;
      default:  state_next = WARM;
    endcase
  end

  // State and warm-up counter; both only move on qualified samples.
  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      state    <= WARM;
      warm_cnt <= '0;
    end else if (sample_en) begin
      state <= state_next;
      if (state == WARM)
        warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  // Beat qualification: glitch rejection, timeout detection and amplitude saturation.
  always_comb begin
    since_inc   = (since_peak == MAX_P) ? since_peak : since_peak + PERIOD_W'(1);
    period_cand = since_peak + PERIOD_W'(1);
    accept      = peak_confirm && has_ref && (period_cand >= MIN_P);
    timeout_hit = sample_en && !peak_confirm && has_ref && (since_inc == MAX_P);
    amp_next    = (extremum >= trough_value) ? (extremum - trough_value) : '0;
  end

  // Registered outputs, period counter and reference-peak bookkeeping.
  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      pulse_valid  <= 1'b0;
      pulse_period <= '0;
      peak_value   <= '0;
      trough_value <= '0;
      amplitude    <= '0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      since_peak   <= '0;
      has_ref      <= 1'b0;
    end else begin
      pulse_valid <= 1'b0;
      timeout     <= 1'b0;
      if (sample_en) begin
        if (peak_confirm) begin
          peak_value <= extremum;
          if (!has_ref) begin
            has_ref    <= 1'b1;
            since_peak <= '0;
          end else if (accept) begin
            pulse_period <= period_cand;
            amplitude    <= amp_next;
            pulse_valid  <= 1'b1;
            locked       <= 1'b1;
            since_peak   <= '0;
          end else begin
            since_peak <= since_inc;
          end
        end else if (timeout_hit) begin
          timeout    <= 1'b1;
          locked     <= 1'b0;
          has_ref    <= 1'b0;
          since_peak <= since_inc;
        end else begin
          since_peak <= since_inc;
        end
        if (trough_confirm)
          trough_value <= extremum;
      end
    end
  end

endmodule

// File: tb/tb_fir_pulse_detector.sv
// Directed self-checking bench for fir_pulse_detector: warm-up, clean and noisy
// triangles, timeout, glitch rejection and asynchronous reset.
module tb_fir_pulse_detector;

  localparam int DW = 20;
  localparam int PW = 16;

  logic          CLK_Filter = 1'b0;
  logic          rst_n;
  logic          sample_en;
  logic [DW-1:0] Filtered_In;
  logic          pulse_valid;
  logic [PW-1:0] pulse_period;
  logic [DW-1:0] peak_value;
  logic [DW-1:0] trough_value;
  logic [DW-1:0] amplitude;
  logic          locked;
  logic          timeout;

  int total = 0;
  int bad = 0;
  int pulse_count = 0;
  int timeout_count = 0;
  int base = 0;
  logic last_timeout = 1'b0;

  fir_pulse_detector dut (
    .CLK_Filter   (CLK_Filter),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .Filtered_In  (Filtered_In),
    .pulse_valid  (pulse_valid),
    .pulse_period (pulse_period),
    .peak_value   (peak_value),
    .trough_value (trough_value),
    .amplitude    (amplitude),
    .locked       (locked),
    .timeout      (timeout)
  );

  // Free-running 100 MHz filter clock.
  always #5 CLK_Filter = ~CLK_Filter;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pulse_valid"},  32'(pulse_valid),  0);
    checkOutput({tag, "_pulse_period"}, 32'(pulse_period), 0);
    checkOutput({tag, "_peak"},         32'(peak_value),   0);
    checkOutput({tag, "_trough"},       32'(trough_value), 0);
    checkOutput({tag, "_amplitude"},    32'(amplitude),    0);
    checkOutput({tag, "_locked"},       32'(locked),       0);
    checkOutput({tag, "_timeout"},      32'(timeout),      0);
  endtask

  // One qualified sample followed by one idle cycle carrying garbage data.
  // Every beat in this bench is a 0..1000 triangle at period 50.
  task automatic applyStimulus(input logic [DW-1:0] value);
    @(negedge CLK_Filter);
    sample_en   = 1'b1;
    Filtered_In = value;
    @(posedge CLK_Filter);
    #1;
    last_timeout = timeout;
    if (timeout) timeout_count++;
    if (pulse_valid) begin
      pulse_count++;
      checkOutput("beat_period",    32'(pulse_period), 50);
      checkOutput("beat_peak",      32'(peak_value),   1000);
      checkOutput("beat_trough",    32'(trough_value), 0);
      checkOutput("beat_amplitude", 32'(amplitude),    1000);
      checkOutput("beat_locked",    32'(locked),       1);
    end
    @(negedge CLK_Filter);
    sample_en   = 1'b0;
    Filtered_In = DW'($urandom);
    @(posedge CLK_Filter);
    #1;
    checkOutput("strobe_clear", {30'd0, pulse_valid, timeout}, 0);
  endtask

  function automatic logic [DW-1:0] triWave(input int phase, input bit noisy, input int glitch_phase);
    int p;
    int v;
    p = phase % 50;
    v = (p <= 25) ? 40 * p : 40 * (50 - p);
    if (noisy && p != 0 && p != 25)
      v = v + (((p % 2) == 0) ? 30 : -30);
    if (p == glitch_phase)
      v = 800;
    return DW'(v);
  endfunction

  task automatic sendTriangle(input int first_phase, input int count, input bit noisy, input int glitch_phase);
    for (int i = 0; i < count; i++)
      applyStimulus(triWave(first_phase + i, noisy, glitch_phase));
  endtask

  task automatic resetDut();
    @(negedge CLK_Filter);
    rst_n     = 1'b1;
    sample_en = 1'b0;
    repeat (2) @(negedge CLK_Filter);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b1;
    sample_en   = 1'b0;
    Filtered_In = '0;
    repeat (3) @(posedge CLK_Filter);
    #1;
    checkAllZero("reset");
    @(negedge CLK_Filter);
    rst_n = 1'b0;

    // Flat input: no extrema, no reference, so nothing may fire.
    repeat (30) applyStimulus(DW'(500));
    checkOutput("const_pulses",   32'(pulse_count),   0);
    checkOutput("const_timeouts", 32'(timeout_count), 0);
    checkAllZero("const");

    // Clean triangle from reset: peaks confirm at samples 27,77,..,227; first is silent.
    resetDut();
    base = pulse_count;
    sendTriangle(0, 250, 1'b0, -1);
    checkOutput("tri_pulses",    32'(pulse_count - base), 4);
    checkOutput("tri_period",    32'(pulse_period),       50);
    checkOutput("tri_amplitude", 32'(amplitude),          1000);
    checkOutput("tri_locked",    32'(locked),             1);

    // Same triangle with +-30 noise: identical beats.
    base = pulse_count;
    sendTriangle(0, 250, 1'b1, -1);
    checkOutput("noise_pulses",   32'(pulse_count - base), 5);
    checkOutput("noise_timeouts", 32'(timeout_count),      0);

    // Hold at 900 right after the top: first hold sample confirms a peak, timeout 400 samples later.
    base = pulse_count;
    sendTriangle(0, 27, 1'b0, -1);
    applyStimulus(DW'(900));
    checkOutput("hold_pulse", 32'(pulse_count - base), 1);
    repeat (399) applyStimulus(DW'(900));
    checkOutput("hold_no_timeout_yet", 32'(timeout_count), 0);
    checkOutput("hold_still_locked",   32'(locked),        1);
    applyStimulus(DW'(900));
    checkOutput("timeout_strobe", 32'(last_timeout), 1);
    checkOutput("timeout_unlock", 32'(locked),       0);
    repeat (20) applyStimulus(DW'(900));
    checkOutput("timeout_once", 32'(timeout_count),      1);
    checkOutput("hold_pulses",  32'(pulse_count - base), 1);

    // Resume: first peak only re-establishes the reference.
    base = pulse_count;
    sendTriangle(0, 31, 1'b0, -1);
    checkOutput("resume_silent", 32'(pulse_count - base), 0);
    checkOutput("resume_unlocked", 32'(locked), 0);
    checkOutput("resume_peak",   32'(peak_value), 1000);
    sendTriangle(31, 119, 1'b0, -1);
    checkOutput("resume_pulses", 32'(pulse_count - base), 2);
    checkOutput("resume_locked", 32'(locked), 1);

    // Sharp 200-LSB bump: trough 600 at phase 35, glitch peak 800 confirmed 10 samples after the beat.
    base = pulse_count;
    sendTriangle(0, 38, 1'b0, 36);
    checkOutput("glitch_pulses",    32'(pulse_count - base), 1);
    checkOutput("glitch_peak",      32'(peak_value),   800);
    checkOutput("glitch_trough",    32'(trough_value), 600);
    checkOutput("glitch_amplitude", 32'(amplitude),    1000);
    sendTriangle(38, 43, 1'b0, -1);
    checkOutput("after_glitch_pulses", 32'(pulse_count - base), 2);
    checkOutput("after_glitch_trough", 32'(trough_value), 0);

    // Asynchronous reset while locked in SEEK_MIN.
    checkOutput("pre_reset_locked", 32'(locked), 1);
    #2;
    rst_n = 1'b1;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(posedge CLK_Filter);
    @(negedge CLK_Filter);
    rst_n = 1'b0;

    // 24 samples swallowed: only the 24th (400) seeds the tracker, then 300 confirms it.
    base = pulse_count;
    repeat (23) applyStimulus(DW'(2000));
    applyStimulus(DW'(400));
    checkOutput("warm_peak_hold", 32'(peak_value), 0);
    applyStimulus(DW'(300));
    checkOutput("warm_first_peak", 32'(peak_value), 400);
    checkOutput("warm_no_pulse",   32'(pulse_count - base), 0);
    checkOutput("warm_unlocked",   32'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
